// File: rtl/instr_mem_arbiter_pkg.sv
// Shared types for the instruction-memory arbiter: address/instruction words,
// fetcher and arbiter-channel state encodings.
package instr_mem_arbiter_pkg;

    localparam int INSTRUCTION_MEMORY_ADDRESS_WIDTH = 8;
    localparam int INSTRUCTION_WIDTH                = 32;

    typedef logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] instruction_memory_address_t;
    typedef logic [INSTRUCTION_WIDTH-1:0]                instruction_t;

    typedef enum logic [2:0] {
        FETCHER_IDLE     = 3'b000,
        FETCHER_FETCHING = 3'b001,
        FETCHER_FETCHED  = 3'b010
    } fetcher_state_t;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'b00,
        ARB_WAITING  = 2'b01,
        ARB_RELAYING = 2'b10,
        ARB_DONE     = 2'b11
    } arb_channel_state_t;

    // Index width that stays legal when there is only one consumer.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/instr_mem_channel.sv
// One instruction-memory read channel: owns a granted consumer from grant
// until that consumer drops its request.
//   state        | meaning
//   ARB_IDLE     | free; accepts a grant from the top-level arbiter
//   ARB_WAITING  | request on memory, waiting for mem_read_ready
//   ARB_RELAYING | data returned to consumer this cycle
//   ARB_DONE     | waiting for the consumer to drop valid
module instr_mem_channel
    import instr_mem_arbiter_pkg::*;
#(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_WIDTH    = INSTRUCTION_MEMORY_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = INSTRUCTION_WIDTH,
    localparam int IDX_W        = idx_width(NUM_CONSUMERS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  grant_valid,
    input  logic [IDX_W-1:0]      grant_idx,
    input  logic [ADDR_WIDTH-1:0] grant_address,
    input  logic                  granted_consumer_valid,
    input  logic                  mem_read_ready,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  idle,
    output logic [IDX_W-1:0]      granted_idx,
    output logic                  mem_read_valid,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    output logic                  ret_valid,
    output logic [DATA_WIDTH-1:0] ret_data
);

    arb_channel_state_t    state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  mem_valid_q, mem_valid_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        ret_valid   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (grant_valid) begin
                    idx_d       = grant_idx;
                    mem_addr_d  = grant_address;
                    mem_valid_d = 1'b1;
                    state_d     = ARB_WAITING;
                end
            end
            ARB_WAITING: begin
                if (mem_read_ready) begin
                    ret_valid   = 1'b1;
                    mem_valid_d = 1'b0;
                    state_d     = ARB_RELAYING;
                end
            end
            ARB_RELAYING: state_d = ARB_DONE;
            // Holding here until valid drops keeps a stale request from being re-granted.
            ARB_DONE: begin
                if (!granted_consumer_valid) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            idx_q       <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    assign idle             = (state_q == ARB_IDLE);
    assign granted_idx      = idx_q;
    assign mem_read_valid   = mem_valid_q;
    assign mem_read_address = mem_addr_q;
    assign ret_data         = mem_read_data;

endmodule

// File: rtl/instr_mem_arbiter.sv
// Arbitrates per-warp instruction fetches onto NUM_CHANNELS memory read channels.
// Define INSTR_MEM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module instr_mem_arbiter
    import instr_mem_arbiter_pkg::*;
#(
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int ADDR_WIDTH    = INSTRUCTION_MEMORY_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = INSTRUCTION_WIDTH
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_WIDTH-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0] consumer_read_data,
    output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  mem_read_data
);

    localparam int IDX_W = idx_width(NUM_CONSUMERS);

    logic [NUM_CHANNELS-1:0]                 ch_idle, ch_grant_valid, ch_cons_valid, ch_ret_valid;
    logic [NUM_CHANNELS-1:0][IDX_W-1:0]      ch_idx, ch_grant_idx;
    logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] ch_grant_addr;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] ch_ret_data;
    logic [NUM_CONSUMERS-1:0]                held_mask;

    logic [NUM_CONSUMERS-1:0]                 ready_q, ready_d;
    logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0] data_q, data_d;
`ifdef INSTR_MEM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
`endif

    always_comb begin
        held_mask = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (!ch_idle[ch]) begin
                held_mask[ch_idx[ch]] = 1'b1;
            end
        end
    end

    // Idle channels claim consumers in ascending channel order so no consumer is granted twice.
    always_comb begin
        logic [NUM_CONSUMERS-1:0] claimed;
        logic                     found;
        int                       cand;
        logic [IDX_W-1:0]         cidx;
        claimed        = held_mask;
        found          = 1'b0;
        cand           = 0;
        cidx           = '0;
        ch_grant_valid = '0;
        ch_grant_idx   = '0;
        ch_grant_addr  = '0;
`ifdef INSTR_MEM_ARB_ROUND_ROBIN_EN
        rr_ptr_d = rr_ptr_q;
`endif
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            found = 1'b0;
            if (ch_idle[ch]) begin
                for (int k = 0; k < NUM_CONSUMERS; k++) begin
`ifdef INSTR_MEM_ARB_ROUND_ROBIN_EN
                    cand = int'(rr_ptr_q) + k;
                    if (cand >= NUM_CONSUMERS) begin
                        cand = cand - NUM_CONSUMERS;
                    end
`else
                    cand = k;
`endif
                    cidx = IDX_W'(cand);
                    if (!found && consumer_read_valid[cidx] && !claimed[cidx]) begin
                        found              = 1'b1;
                        claimed[cidx]      = 1'b1;
                        ch_grant_valid[ch] = 1'b1;
                        ch_grant_idx[ch]   = cidx;
                        ch_grant_addr[ch]  = consumer_read_address[cidx];
`ifdef INSTR_MEM_ARB_ROUND_ROBIN_EN
                        rr_ptr_d = (cand == NUM_CONSUMERS - 1) ? '0 : IDX_W'(cand + 1);
`endif
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_channel
        assign ch_cons_valid[g] = consumer_read_valid[ch_idx[g]];

        instr_mem_channel #(
            .NUM_CONSUMERS(NUM_CONSUMERS),
            .ADDR_WIDTH   (ADDR_WIDTH),
            .DATA_WIDTH   (DATA_WIDTH)
        ) u_channel (
            .clk                   (clk),
            .reset                 (reset),
            .grant_valid           (ch_grant_valid[g]),
            .grant_idx             (ch_grant_idx[g]),
            .grant_address         (ch_grant_addr[g]),
            .granted_consumer_valid(ch_cons_valid[g]),
            .mem_read_ready        (mem_read_ready[g]),
            .mem_read_data         (mem_read_data[g]),
            .idle                  (ch_idle[g]),
            .granted_idx           (ch_idx[g]),
            .mem_read_valid        (mem_read_valid[g]),
            .mem_read_address      (mem_read_address[g]),
            .ret_valid             (ch_ret_valid[g]),
            .ret_data              (ch_ret_data[g])
        );
    end

    always_comb begin
        ready_d = '0;
        data_d  = data_q;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (ch_ret_valid[ch]) begin
                ready_d[ch_idx[ch]] = 1'b1;
                data_d[ch_idx[ch]]  = ch_ret_data[ch];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q  <= '0;
            data_q   <= '0;
`ifdef INSTR_MEM_ARB_ROUND_ROBIN_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            ready_q  <= ready_d;
            data_q   <= data_d;
`ifdef INSTR_MEM_ARB_ROUND_ROBIN_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign consumer_read_ready = ready_q;
    assign consumer_read_data  = data_q;

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Directed bench for instr_mem_arbiter: one single-channel and one dual-channel instance.
module tb_instr_mem_arbiter;
    localparam int NC = 4;
    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NC-1:0]          v1, r1;
    logic [NC-1:0][AW-1:0]  a1;
    logic [NC-1:0][DW-1:0]  d1;
    logic [0:0]             mv1, mr1;
    logic [0:0][AW-1:0]     ma1;
    logic [0:0][DW-1:0]     md1;

    logic [NC-1:0]          v2, r2;
    logic [NC-1:0][AW-1:0]  a2;
    logic [NC-1:0][DW-1:0]  d2;
    logic [1:0]             mv2, mr2;
    logic [1:0][AW-1:0]     ma2;
    logic [1:0][DW-1:0]     md2;

    instr_mem_arbiter #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut1 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(v1), .consumer_read_address(a1),
        .consumer_read_ready(r1), .consumer_read_data(d1),
        .mem_read_valid(mv1), .mem_read_address(ma1),
        .mem_read_ready(mr1), .mem_read_data(md1)
    );

    instr_mem_arbiter #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut2 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(v2), .consumer_read_address(a2),
        .consumer_read_ready(r2), .consumer_read_data(d2),
        .mem_read_valid(mv2), .mem_read_address(ma2),
        .mem_read_ready(mr2), .mem_read_data(md2)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  v;
        logic        mr;
        logic [31:0] md;
        logic [3:0]  rdy;
        logic        mv;
        logic [7:0]  ma;
        logic [31:0] d0;
        logic [31:0] dd2;
    } vec_t;
    vec_t vt[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] addr_of(input int c);
        return 8'((c + 1) * 16);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[$];
        int exp_order[5];
        logic [3:0] pend, low;
        int rcnt1, rcnt3, extra_req, extra_rdy;

        reset = 1'b1;
        v1 = '0; mr1 = '0; md1 = '0;
        v2 = '0; mr2 = '0; md2 = '0;
        for (int c = 0; c < NC; c++) begin
            a1[c] = addr_of(c);
            a2[c] = addr_of(c);
        end
        vt[0]  = '{4'h1, 1'b0, 32'h0,        4'h0, 1'b1, 8'h10, 32'h0,        32'h0};
        vt[1]  = '{4'h1, 1'b1, 32'hDEADBEEF, 4'h1, 1'b0, 8'h10, 32'hDEADBEEF, 32'h0};
        vt[2]  = '{4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 8'h10, 32'hDEADBEEF, 32'h0};
        vt[3]  = '{4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 8'h10, 32'hDEADBEEF, 32'h0};
        vt[4]  = '{4'h4, 1'b0, 32'h0,        4'h0, 1'b1, 8'h30, 32'hDEADBEEF, 32'h0};
        for (int i = 5; i < 10; i++)
            vt[i] = '{4'h4, 1'b0, 32'h0,     4'h0, 1'b1, 8'h30, 32'hDEADBEEF, 32'h0};
        vt[10] = '{4'h4, 1'b1, 32'h12345678, 4'h4, 1'b0, 8'h30, 32'hDEADBEEF, 32'h12345678};
        vt[11] = '{4'h4, 1'b0, 32'h0,        4'h0, 1'b0, 8'h30, 32'hDEADBEEF, 32'h12345678};
        vt[12] = '{4'h4, 1'b1, 32'hBAD0BAD0, 4'h0, 1'b0, 8'h30, 32'hDEADBEEF, 32'h12345678};
        vt[13] = '{4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 8'h30, 32'hDEADBEEF, 32'h12345678};
        vt[14] = '{4'h0, 1'b1, 32'hBAD0BAD0, 4'h0, 1'b0, 8'h30, 32'hDEADBEEF, 32'h12345678};

        repeat (2) step();
        reset = 1'b0;

        check("reset ready1", 64'(r1), 64'h0);
        check("reset mvalid1", 64'(mv1), 64'h0);
        check("reset maddr1", 64'(ma1[0]), 64'h0);
        check("reset mvalid2", 64'(mv2), 64'h0);
        check("reset ready2", 64'(r2), 64'h0);
        for (int c = 0; c < NC; c++) check($sformatf("reset data1[%0d]", c), 64'(d1[c]), 64'h0);

        // single-consumer transactions, 5-cycle stall, overlong valid, stray responses
        for (int i = 0; i < 15; i++) begin
            v1 = vt[i].v; mr1[0] = vt[i].mr; md1[0] = vt[i].md;
            step();
            check($sformatf("vec%0d ready", i), 64'(r1), 64'(vt[i].rdy));
            check($sformatf("vec%0d mvalid", i), 64'(mv1), 64'(vt[i].mv));
            check($sformatf("vec%0d maddr", i), 64'(ma1[0]), 64'(vt[i].ma));
            check($sformatf("vec%0d data0", i), 64'(d1[0]), 64'(vt[i].d0));
            check($sformatf("vec%0d data2", i), 64'(d1[2]), 64'(vt[i].dd2));
        end
        v1 = '0; mr1 = '0;

        // all four consumers request continuously on one channel
        reset = 1'b1;
        step();
        reset = 1'b0;
`ifdef INSTR_MEM_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        pend = '0; low = '0;
        v1 = 4'hF;
        for (int cyc = 0; cyc < 200 && order.size() < 5; cyc++) begin
            step();
            mr1[0] = mv1[0];
            md1[0] = 32'hA000_0000 | 32'(ma1[0]);
            for (int c = 0; c < NC; c++) begin
                if (low[c]) begin
                    v1[c] = 1'b1; low[c] = 1'b0;
                end else if (pend[c]) begin
                    v1[c] = 1'b0; pend[c] = 1'b0; low[c] = 1'b1;
                end
                if (r1[c]) begin
                    order.push_back(c);
                    pend[c] = 1'b1;
                    check($sformatf("arb data%0d", c), 64'(d1[c]), 64'(32'hA000_0000 | 32'(addr_of(c))));
                end
            end
        end
        check("arb grant count", 64'(order.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < order.size())
                check($sformatf("arb grant%0d", i), 64'(order[i]), 64'(exp_order[i]));
        end
        v1 = '0;
        for (int i = 0; i < 6; i++) begin
            mr1[0] = mv1[0];
            step();
        end
        mr1 = '0;

        // two channels, consumers 1 and 3 together
        v2 = 4'b1010;
        step();
        check("dual mvalid", 64'(mv2), 64'h3);
        check("dual maddr0", 64'(ma2[0]), 64'h20);
        check("dual maddr1", 64'(ma2[1]), 64'h40);
        mr2 = 2'b11; md2[0] = 32'h0000_00B1; md2[1] = 32'h0000_00B3;
        step();
        check("dual ready", 64'(r2), 64'hA);
        check("dual data1", 64'(d2[1]), 64'hB1);
        check("dual data3", 64'(d2[3]), 64'hB3);
        check("dual mvalid after", 64'(mv2), 64'h0);
        rcnt1 = 1; rcnt3 = 1; extra_req = 0; extra_rdy = 0;
        mr2 = '0;
        step();
        v2 = '0;
        for (int i = 0; i < 6; i++) begin
            mr2 = mv2;
            if (mv2 != 2'b00) extra_req++;
            if (r2[1]) rcnt1++;
            if (r2[3]) rcnt3++;
            if (r2[0] || r2[2]) extra_rdy++;
            step();
        end
        check("dual count1", 64'(rcnt1), 64'd1);
        check("dual count3", 64'(rcnt3), 64'd1);
        check("dual extra requests", 64'(extra_req), 64'd0);
        check("dual extra readies", 64'(extra_rdy), 64'd0);
        mr2 = '0;

        // reset while WAITING discards the outstanding response
        v1 = 4'b0010;
        step();
        check("rst pre mvalid", 64'(mv1), 64'h1);
        check("rst pre maddr", 64'(ma1[0]), 64'h20);
        reset = 1'b1; v1 = '0; mr1 = 1'b1; md1[0] = 32'hFEED_FACE;
        step();
        check("rst mvalid", 64'(mv1), 64'h0);
        check("rst maddr", 64'(ma1[0]), 64'h0);
        check("rst ready", 64'(r1), 64'h0);
        for (int c = 0; c < NC; c++) check($sformatf("rst data%0d", c), 64'(d1[c]), 64'h0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("post rst ready%0d", i), 64'(r1), 64'h0);
            check($sformatf("post rst mvalid%0d", i), 64'(mv1), 64'h0);
        end
        mr1 = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
